// File: rtl/uart_cmd_pkt_if.sv
// Byte/command/response bundle between the UART transceiver, the framer and
// the command processor. The framer connects through the slave modport.
interface uart_cmd_pkt_if #(
  parameter int CMD_BYTES  = 3,
  parameter int RESP_BYTES = 1
);
  logic                    rx_rdy;
  logic [7:0]              rx_data;
  logic                    rx_clr_rdy;
  logic [8*CMD_BYTES-1:0]  cmd;
  logic                    cmd_rdy;
  logic                    clr_cmd_rdy;
  logic                    cmd_err;
  logic [8*RESP_BYTES-1:0] resp;
  logic                    send_resp;
  logic                    resp_busy;
  logic                    tx_trmt;
  logic [7:0]              tx_data;
  logic                    tx_done;
  logic                    resp_done;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output rx_clr_rdy, cmd, cmd_rdy, cmd_err, resp_busy, tx_trmt, tx_data, resp_done
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  rx_clr_rdy, cmd, cmd_rdy, cmd_err, resp_busy, tx_trmt, tx_data, resp_done
  );
endinterface

// File: rtl/uart_cmd_pkt.sv
// UART command/response framer: assembles CMD_BYTES received bytes into a
// command word with an inter-byte timeout, and serialises a RESP_BYTES
// response into back-to-back transmitter requests.
// Optional: define UART_CMD_CHKSUM_EN to require a trailing checksum byte
// (8-bit sum of all bytes incl. checksum must be zero).
module uart_cmd_pkt #(
  parameter int CMD_BYTES  = 3,
  parameter int RESP_BYTES = 1,
  parameter int TMO_CYCLES = 1000000,
  parameter int MSB_FIRST  = 1
) (
  input logic             clk,
  input logic             rst_n,
  uart_cmd_pkt_if.slave   bus
);
`ifdef UART_CMD_CHKSUM_EN
  localparam int NBYTES = CMD_BYTES + 1;
`else
  localparam int NBYTES = CMD_BYTES;
`endif
  localparam int CW = 8*CMD_BYTES;
  localparam int TW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);
  localparam logic [3:0] BLAST = 4'(NBYTES - 1);
  localparam logic [2:0] KLAST = 3'(RESP_BYTES - 1);

  // ---------------- RX path ----------------
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] asm_q, asm_shift, word;
  logic [CW-1:0] cmd_q;
  logic          cmd_rdy_q, cmd_err_q;
  logic          accept, last, tmo_run, tmo_hit, done_ok, chk_fail;

  assign accept         = bus.rx_rdy;
  assign bus.rx_clr_rdy = accept;
  assign last           = (bcnt == BLAST);
  assign tmo_run        = (bcnt != 4'd0) && !accept;
  assign tmo_hit        = (TMO_CYCLES != 0) && tmo_run && (tcnt == TMO_LAST);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign asm_shift = {asm_q[CW-9:0], bus.rx_data};
    end else begin : g_lsb
      assign asm_shift = {bus.rx_data, asm_q[CW-1:8]};
    end
  endgenerate

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] sum_q, sum_nxt;
  assign sum_nxt  = sum_q + bus.rx_data;
  // the checksum byte never enters the assembly register
  assign word     = asm_q;
  assign done_ok  = accept && last && (sum_nxt == 8'h00);
  assign chk_fail = accept && last && (sum_nxt != 8'h00);

  // running byte sum of the command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sum_q <= '0;
    else if (accept)         sum_q <= last ? 8'h00 : sum_nxt;
    else if (tmo_hit)        sum_q <= '0;
  end
`else
  assign word     = asm_shift;
  assign done_ok  = accept && last;
  assign chk_fail = 1'b0;
`endif

  // byte counter, assembly register, timeout and command hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt      <= '0;
      tcnt      <= '0;
      asm_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= tmo_hit | chk_fail;
      if (accept) begin
        tcnt  <= '0;
        bcnt  <= last ? 4'd0 : bcnt + 4'd1;
        asm_q <= last ? '0 : asm_shift;
      end else if (tmo_hit) begin
        tcnt  <= '0;
        bcnt  <= '0;
        asm_q <= '0;
      end else if (tmo_run) begin
        tcnt  <= tcnt + 1'b1;
      end
      // completion beats a simultaneous acknowledge
      if (done_ok) begin
        cmd_q     <= word;
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.cmd_err = cmd_err_q;

  // ---------------- TX path ----------------
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
  tx_state_t state, state_n;

  logic [RESP_BYTES-1:0][7:0] rsh;
  logic [2:0] k;
  logic [7:0] tx_data_q;
  logic       trmt_q, busy_q, done_q;
  logic       ld, adv, fin;

  // byte idx of the response in wire order
  function automatic logic [7:0] pick(input logic [RESP_BYTES-1:0][7:0] w, input logic [2:0] idx);
    pick = '0;
    for (int i = 0; i < RESP_BYTES; i++)
      if (3'((MSB_FIRST != 0) ? RESP_BYTES - 1 - i : i) == idx) pick = w[i];
  endfunction

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_n;
  end

  // TX next state and control strobes; tx_done is ignored while tx_trmt is high
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    case (state)
      TX_IDLE: if (bus.send_resp) begin
        ld      = 1'b1;
        state_n = TX_WAIT;
      end
      TX_WAIT: if (bus.tx_done && !trmt_q) begin
        if (k == KLAST) begin
          fin     = 1'b1;
          state_n = TX_IDLE;
        end else begin
          adv     = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // TX datapath: latch response, walk byte index, drive transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsh       <= '0;
      k         <= '0;
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trmt_q <= ld | adv;
      done_q <= fin;
      if (ld) begin
        rsh       <= bus.resp;
        k         <= '0;
        tx_data_q <= pick(bus.resp, 3'd0);
        busy_q    <= 1'b1;
      end else if (adv) begin
        k         <= k + 3'd1;
        tx_data_q <= pick(rsh, k + 3'd1);
      end else if (fin) begin
        busy_q    <= 1'b0;
      end
    end
  end

  assign bus.tx_trmt   = trmt_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.resp_busy = busy_q;
  assign bus.resp_done = done_q;
endmodule
